// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, depth derivation and word types for the register file.
package rf_pkg;
  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;
  localparam int RF_N_RD = 2;
  localparam int RF_DEPTH = 2 ** RF_ADDR_W;
  typedef logic [RF_DATA_W-1:0] data_t;
  typedef logic [RF_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read mux with zero-register, bypass and ready logic.
module rf_read_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0]                 i_addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]  i_regs,
  input  logic [2**ADDR_W-1:0]              i_pend,
  input  logic                              i_wen,
  input  logic [ADDR_W-1:0]                 i_waddr,
  input  logic [DATA_W-1:0]                 i_wdata,
  output logic [DATA_W-1:0]                 o_data,
  output logic                              o_rdy
);
  logic w_zero, w_byp;
  assign w_zero = ZERO_REG && (i_addr == '0);
  assign w_byp = BYPASS && i_wen && (i_waddr == i_addr);
  assign o_data = w_zero ? '0 : w_byp ? i_wdata : i_regs[i_addr];
  assign o_rdy = w_zero || w_byp || !i_pend[i_addr];
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-read-port register file with per-register
// pending scoreboard, pending count and sticky double-reserve error.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int N_RD = RF_N_RD,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   WEN,
  input  logic [ADDR_W-1:0]      RW,
  input  logic [DATA_W-1:0]      busW,
  input  logic                   RES_EN,
  input  logic [ADDR_W-1:0]      RES_ADDR,
  input  logic [N_RD*ADDR_W-1:0] RA,
  output logic [N_RD*DATA_W-1:0] busR,
  output logic [N_RD-1:0]        rdy,
  output logic [ADDR_W:0]        pend_cnt,
  output logic                   err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_pend;
  logic [ADDR_W:0]              r_cnt;
  logic                         r_err;
  logic                         w_we, w_res, w_dup;
  logic [DEPTH-1:0]             w_pend_nxt;
  logic [ADDR_W:0]              w_cnt_nxt;
  assign w_we = WEN && !(ZERO_REG && (RW == '0));
  assign w_res = RES_EN && !(ZERO_REG && (RES_ADDR == '0));
  assign w_dup = w_res && r_pend[RES_ADDR] && !(w_we && (RW == RES_ADDR));
  // reserve is applied after the write so a same-address reserve leaves the register pending
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_we) w_pend_nxt[RW] = 1'b0;
    if (w_res) w_pend_nxt[RES_ADDR] = 1'b1;
  end
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_pend_nxt[i]);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_mem <= '0;
      r_pend <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_we) r_mem[RW] <= busW;
      r_pend <= w_pend_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_dup;
    end
  end
  assign pend_cnt = r_cnt;
  assign err = r_err;
  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS(BYPASS)
    ) u_rd (
      .i_addr(RA[i*ADDR_W +: ADDR_W]),
      .i_regs(r_mem),
      .i_pend(r_pend),
      .i_wen(WEN),
      .i_waddr(RW),
      .i_wdata(busW),
      .o_data(busR[i*DATA_W +: DATA_W]),
      .o_rdy(rdy[i])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed bench for the default 8x8/2-port file and a 16x16/3-port
// no-bypass file, checked against a behavioural model every cycle plus literal expectations.
module tb_register_file_mp;
  import rf_pkg::*;
  logic clk = 0, rst = 1, armed = 0;
  int checks = 0, errors = 0;
  logic a_wen = 0, a_res = 0;
  logic [2:0] a_rw = 0, a_resa = 0;
  data_t a_busw = 0;
  logic [5:0] a_ra = 0;
  logic [15:0] a_busr;
  logic [1:0] a_rdy;
  logic [3:0] a_cnt;
  logic a_err;
  logic b_wen = 0, b_res = 0;
  logic [3:0] b_rw = 0, b_resa = 0;
  logic [15:0] b_busw = 0;
  logic [11:0] b_ra = 0;
  logic [47:0] b_busr;
  logic [2:0] b_rdy;
  logic [4:0] b_cnt;
  logic b_err;
  register_file_mp u_a (
    .Clk(clk), .Rst(rst), .WEN(a_wen), .RW(a_rw), .busW(a_busw), .RES_EN(a_res),
    .RES_ADDR(a_resa), .RA(a_ra), .busR(a_busr), .rdy(a_rdy), .pend_cnt(a_cnt), .err(a_err)
  );
  register_file_mp #(.DATA_W(16), .ADDR_W(4), .N_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
    .Clk(clk), .Rst(rst), .WEN(b_wen), .RW(b_rw), .busW(b_busw), .RES_EN(b_res),
    .RES_ADDR(b_resa), .RA(b_ra), .busR(b_busr), .rdy(b_rdy), .pend_cnt(b_cnt), .err(b_err)
  );
  always #5 clk = ~clk;
  // model: k=0 is the default instance, k=1 the wide no-bypass instance
  logic [15:0] m_mem [2][16];
  bit m_pend [2][16];
  bit m_err [2];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic upd(input int k, input bit wen, input int rw, input logic [15:0] d,
                     input bit re, input int ra);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[k][i] = 0;
        m_pend[k][i] = 0;
      end
      m_err[k] = 0;
    end else begin
      if (re && ra != 0 && m_pend[k][ra] && !(wen && rw == ra)) m_err[k] = 1;
      if (wen && rw != 0) begin
        m_mem[k][rw] = d;
        m_pend[k][rw] = 0;
      end
      if (re && ra != 0) m_pend[k][ra] = 1;
    end
  endtask
  function automatic int npend(input int k);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_pend[k][i]);
    return c;
  endfunction
  function automatic void exp_rd(input int k, input bit byp, input int a, input bit wen,
                                 input int rw, input logic [15:0] d,
                                 output logic [15:0] v, output bit r);
    if (a == 0) begin
      v = 0;
      r = 1;
    end else if (byp && wen && rw == a) begin
      v = d;
      r = 1;
    end else begin
      v = m_mem[k][a];
      r = !m_pend[k][a];
    end
  endfunction
  always @(posedge clk) begin
    upd(0, a_wen, int'(a_rw), 16'(a_busw), a_res, int'(a_resa));
    upd(1, b_wen, int'(b_rw), b_busw, b_res, int'(b_resa));
  end
  always @(negedge clk) begin
    logic [15:0] v;
    bit r;
    if (armed) begin
      for (int p = 0; p < 2; p++) begin
        exp_rd(0, 1, int'(a_ra[p*3 +: 3]), a_wen, int'(a_rw), 16'(a_busw), v, r);
        chk($sformatf("m_a_busr%0d", p), 64'(a_busr[p*8 +: 8]), 64'(v[7:0]));
        chk($sformatf("m_a_rdy%0d", p), 64'(a_rdy[p]), 64'(r));
      end
      chk("m_a_cnt", 64'(a_cnt), 64'(npend(0)));
      chk("m_a_err", 64'(a_err), 64'(m_err[0]));
      for (int p = 0; p < 3; p++) begin
        exp_rd(1, 0, int'(b_ra[p*4 +: 4]), b_wen, int'(b_rw), b_busw, v, r);
        chk($sformatf("m_b_busr%0d", p), 64'(b_busr[p*16 +: 16]), 64'(v));
        chk($sformatf("m_b_rdy%0d", p), 64'(b_rdy[p]), 64'(r));
      end
      chk("m_b_cnt", 64'(b_cnt), 64'(npend(1)));
      chk("m_b_err", 64'(b_err), 64'(m_err[1]));
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
    a_wen = 1;
    a_rw = a;
    a_busw = d;
    tick;
    a_wen = 0;
  endtask
  initial begin
    tick;
    tick;
    rst = 0;
    armed = 1;
    for (int a = 0; a < 8; a++) begin
      a_ra = {3'(a), 3'(a)};
      #1 chk("rst_busr", 64'(a_busr), 64'h0);
      chk("rst_rdy", 64'(a_rdy), 64'h3);
      tick;
    end
    chk("rst_cnt", 64'(a_cnt), 64'h0);
    chk("rst_err", 64'(a_err), 64'h0);
    wr_a(3'd1, 8'hAA);
    wr_a(3'd7, 8'hFF);
    wr_a(3'd0, 8'hCC);
    a_rw = 3'd3;
    a_busw = 8'hCC;
    tick;
    a_ra = {3'd7, 3'd1};
    #1 chk("wr_7_1", 64'(a_busr), 64'hFFAA);
    a_ra = {3'd3, 3'd0};
    #1 chk("wr_3_0", 64'(a_busr), 64'h0000);
    a_res = 1;
    a_resa = 3'd5;
    tick;
    a_res = 0;
    a_ra = {3'd0, 3'd5};
    #1 chk("res5_rdy", 64'(a_rdy), 64'h2);
    chk("res5_cnt", 64'(a_cnt), 64'h1);
    a_wen = 1;
    a_rw = 3'd5;
    a_busw = 8'h33;
    #1 chk("byp_data", 64'(a_busr[7:0]), 64'h33);
    chk("byp_rdy", 64'(a_rdy), 64'h3);
    tick;
    a_wen = 0;
    #1 chk("w5_data", 64'(a_busr[7:0]), 64'h33);
    chk("w5_rdy", 64'(a_rdy), 64'h3);
    chk("w5_cnt", 64'(a_cnt), 64'h0);
    a_res = 1;
    a_resa = 3'd2;
    a_wen = 1;
    a_rw = 3'd2;
    a_busw = 8'h0F;
    tick;
    a_res = 0;
    a_wen = 0;
    a_ra = {3'd0, 3'd2};
    #1 chk("wr_res2_data", 64'(a_busr[7:0]), 64'h0F);
    chk("wr_res2_rdy", 64'(a_rdy), 64'h2);
    chk("wr_res2_cnt", 64'(a_cnt), 64'h1);
    chk("wr_res2_err", 64'(a_err), 64'h0);
    a_res = 1;
    tick;
    a_res = 0;
    #1 chk("dup_err", 64'(a_err), 64'h1);
    tick;
    #1 chk("dup_err_sticky", 64'(a_err), 64'h1);
    a_res = 1;
    for (int i = 1; i < 8; i++) begin
      a_resa = 3'(i);
      tick;
    end
    #1 chk("cnt7", 64'(a_cnt), 64'h7);
    a_resa = 3'd0;
    tick;
    #1 chk("cnt7_res0", 64'(a_cnt), 64'h7);
    rst = 1;
    a_resa = 3'd3;
    a_wen = 1;
    a_rw = 3'd4;
    a_busw = 8'h5A;
    tick;
    rst = 0;
    a_res = 0;
    a_wen = 0;
    #1 chk("rst2_cnt", 64'(a_cnt), 64'h0);
    chk("rst2_err", 64'(a_err), 64'h0);
    for (int a = 0; a < 8; a++) begin
      a_ra = {3'(a), 3'(a)};
      #1 chk("rst2_rdy", 64'(a_rdy), 64'h3);
      chk("rst2_busr", 64'(a_busr), 64'h0);
      tick;
    end
    b_wen = 1;
    b_rw = 4'd15;
    b_busw = 16'hBEEF;
    b_ra = {4'd15, 4'd15, 4'd15};
    #1 chk("b_pre_edge", 64'(b_busr), 64'h0);
    chk("b_pre_rdy", 64'(b_rdy), 64'h7);
    tick;
    b_wen = 0;
    #1 chk("b_post_edge", 64'(b_busr), 64'hBEEF_BEEF_BEEF);
    b_res = 1;
    b_resa = 4'd5;
    tick;
    b_res = 0;
    b_ra = {4'd5, 4'd15, 4'd5};
    #1 chk("b_res5_rdy", 64'(b_rdy), 64'h2);
    chk("b_res5_cnt", 64'(b_cnt), 64'h1);
    b_wen = 1;
    b_rw = 4'd5;
    b_busw = 16'h1234;
    #1 chk("b_nobyp_data", 64'(b_busr), 64'h0000_BEEF_0000);
    chk("b_nobyp_rdy", 64'(b_rdy), 64'h2);
    tick;
    b_wen = 0;
    #1 chk("b_w5_data", 64'(b_busr), 64'h1234_BEEF_1234);
    chk("b_w5_rdy", 64'(b_rdy), 64'h7);
    chk("b_w5_cnt", 64'(b_cnt), 64'h0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
